// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port arbitrated ALU: opcodes, FSM states and
// the bit positions of the packed {ZF,CF,OF,SF,PF} flag vector.
package alu_arb_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SLT   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;

  localparam int FLAG_W  = 5;
  localparam int FLAG_ZF = 4;
  localparam int FLAG_CF = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_PF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb_alu.sv
// Purely combinational ALU: result, status flags and illegal-opcode error.
module alu_arb_alu
  import alu_arb_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic [3:0]        op,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [SIZE-1:0]   f,
  output logic [FLAG_W-1:0] flags,
  output logic              err
);

  localparam int SHW = $clog2(SIZE);

  logic [SIZE:0]   sum;
  logic [SIZE:0]   diff;
  logic [SHW-1:0]  shamt;
  logic            carry;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    f     = '0;
    carry = 1'b0;
    err   = 1'b0;
    case (op)
      OP_AND:   f = a & b;
      OP_OR:    f = a | b;
      OP_ADD:   begin f = sum[SIZE-1:0];  carry = sum[SIZE];  end
      OP_SLL:   f = a << shamt;
      OP_SLT:   f = {{(SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  f = {{(SIZE-1){1'b0}}, (a < b)};
      OP_SUB:   begin f = diff[SIZE-1:0]; carry = diff[SIZE]; end
      OP_XOR:   f = a ^ b;
      OP_SRL:   f = a >> shamt;
      OP_SRA:   f = $signed(a) >>> shamt;
      OP_PASSB: f = b;
      default:  err = 1'b1;
    endcase
  end

  // Illegal opcodes report all-zero flags rather than flags of a zero result.
  always_comb begin
    flags = '0;
    if (!err) begin
      flags[FLAG_ZF] = (f == '0);
      flags[FLAG_CF] = carry;
      flags[FLAG_OF] = a[SIZE-1] ^ b[SIZE-1] ^ f[SIZE-1] ^ carry;
      flags[FLAG_SF] = f[SIZE-1];
      flags[FLAG_PF] = ~^f;
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester front end for a single ALU: round-robin grant in IDLE, one
// cycle of execution, then a held response until the winner consumes it.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [3:0]        req0_op,
  input  logic [3:0]        req1_op,
  input  logic [SIZE-1:0]   req0_a,
  input  logic [SIZE-1:0]   req0_b,
  input  logic [SIZE-1:0]   req1_a,
  input  logic [SIZE-1:0]   req1_b,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic [SIZE-1:0]   rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err,
  output logic              busy
);

  state_t              state;
  state_t              state_nx;
  logic                ptr;
  logic                win;
  logic [3:0]          op_q;
  logic [SIZE-1:0]     a_q;
  logic [SIZE-1:0]     b_q;
  logic                gnt0;
  logic                gnt1;
  logic                accept;
  logic                rsp_hs;
  logic [SIZE-1:0]     alu_f;
  logic [FLAG_W-1:0]   alu_flags;
  logic                alu_err;

  // The pointer only breaks ties; a lone requester always wins.
  assign gnt0   = req0_valid & (~req1_valid | ~ptr);
  assign gnt1   = req1_valid & (~req0_valid |  ptr);
  assign accept = (state == IDLE) & (gnt0 | gnt1);
  assign rsp_hs = (state == RESP) & (win ? rsp1_ready : rsp0_ready);

  assign rsp0_valid = (state == RESP) & ~win;
  assign rsp1_valid = (state == RESP) &  win;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = gnt0 & ~rst;
        req1_ready = gnt1 & ~rst;
        if (gnt0 | gnt1) state_nx = EXEC;
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win       <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        win  <= gnt1;
        op_q <= gnt1 ? req1_op : req0_op;
        a_q  <= gnt1 ? req1_a  : req0_a;
        b_q  <= gnt1 ? req1_b  : req0_b;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_f;
        rsp_flags <= alu_flags;
        rsp_err   <= alu_err;
      end
      if (rsp_hs) ptr <= ~win;
    end
  end

  alu_arb_alu #(.SIZE(SIZE)) alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .f     (alu_f),
    .flags (alu_flags),
    .err   (alu_err)
  );

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 The block SHALL have parameter SIZE, default 64: operand/result width.
REQ-002 The block SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each: requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted this cycle when valid&ready.
REQ-006 The block SHALL have ports req0_op/req1_op, input, 4 each: ALU opcode.
REQ-007 The block SHALL have ports req0_a/req0_b/req1_a/req1_b, input, SIZE each: operands A, B.
REQ-008 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1 each: result available for that requester.
REQ-009 The block SHALL have ports rsp0_ready/rsp1_ready, input, 1 each: requester consumes result.
REQ-010 The block SHALL have port rsp_data, output, SIZE: result F, shared by both response ports.
REQ-011 The block SHALL have port rsp_flags, output, 5: {ZF,CF,OF,SF,PF}.
REQ-012 The block SHALL have port rsp_err, output, 1: illegal opcode.
REQ-013 The block SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, EXEC and RESP, with one operation outstanding at most.
REQ-015 In IDLE, grant SHALL be combinational: a single valid requester wins; if both are valid, the port named by the round-robin pointer wins.
REQ-016 reqN_ready SHALL be 1 only in IDLE for the granted port; both ready signals SHALL be 0 in EXEC and RESP.
REQ-017 On accept, op/A/B and the winner index SHALL be latched, and the FSM SHALL go to EXEC.
REQ-018 EXEC SHALL last 1 cycle; the ALU output, flags and err SHALL be registered, and the FSM SHALL go to RESP.
REQ-019 rspN_valid SHALL be asserted from the cycle after EXEC (accept cycle +2), for the winner only.
REQ-020 rspN_valid SHALL be held, with rsp_data, rsp_flags and rsp_err stable, until rspN_ready=1.
REQ-021 On response handshake: FSM→IDLE; pointer := other port (winner^1); rsp_valid deasserts next cycle.
REQ-022 rspN_ready of the non-winning port SHALL be ignored.
REQ-023 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SLT signed, 0101 SLTU, 0110 SUB, 0111 XOR, 1000 SRL, 1001 SRA, 1010 pass B.
REQ-024 ADD/SUB carry SHALL be bit SIZE of the (SIZE+1)-bit sum/difference; other ops SHALL give CF=0.
REQ-025 ZF SHALL be (F==0), SF SHALL be F[SIZE-1], PF SHALL be ~^F, and OF SHALL be A[msb]^B[msb]^F[msb]^C.
REQ-026 Opcodes 1011–1111 SHALL give rsp_err=1, rsp_data=0 and rsp_flags=0, and still complete a normal handshake.
REQ-027 Requester valid/operands changing while not accepted SHALL have no effect.
REQ-028 Minimum throughput SHALL be 1 op per 3 cycles (zero-wait response).
REQ-029 No requester SHALL wait more than one other operation while continuously valid (fairness).

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set state=IDLE and pointer=0.
REQ-031 While rst=1 at a clock edge, the block SHALL set rsp0_valid=rsp1_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0 and busy=0.
REQ-032 Reset in EXEC or RESP SHALL abort the operation, with no response issued.
REQ-033 The block SHALL NOT assert any ready output in the reset cycle.

Structure
REQ-034 A shared package SHALL hold the opcode constants, the 3-state FSM enum and the flag bit indices.
REQ-035 The block SHALL instantiate exactly one combinational 64-bit ALU sub-module, ALU, fed from the latched operand registers.

Verification
REQ-036 A bench SHALL cover: rst 2 cycles; req0 ADD A=5, B=7 at cycle 3 → ready0=1 @3, rsp0_valid @5, data=12, flags=00001 (PF=1).
REQ-037 A bench SHALL cover: both valid from idle, pointer=0 → port0 served first, port1 accepted in first IDLE after rsp0 handshake; next contention → port1 first.
REQ-038 A bench SHALL cover: SUB A=0, B=1 → data=all-ones, CF=1, SF=1, ZF=0; SLT A=-1, B=1 → 1; SLTU same → 0.
REQ-039 A bench SHALL cover: rsp0_ready low 4 cycles → rsp0_valid and data stable, no new accept, req1_ready=0 throughout.
REQ-040 A bench SHALL cover: op=1111 → rsp_err=1, data=0; next op normal, err=0.
REQ-041 A bench SHALL cover: rst asserted during RESP → rsp valid low next cycle, pointer=0, accepted op lost.
